// File: rtl/sys_inst_injector_if.sv
// sys_inst_injector_if
//   Bundles the fetch-side signals around the system instruction injector.
//   master : fetch/sequencer side (drives stream, memory word, PC; observes results)
//   slave  : the injector itself
//   Signals:
//     sys_active, sys_inst  - sequencer stream flag and word
//     mem_inst, fetch_pc    - instruction-memory word and current PC
//     inst_out              - word forwarded to decode
//     pc_stall, pc_restore  - PC hold / reload-from-saved_pc pulse
//     saved_pc, inj_count   - PC captured at start, words injected
//     seq_done, overrun     - completion pulse, sticky forced-termination flag
interface sys_inst_injector_if;
    logic        sys_active;
    logic [31:0] sys_inst;
    logic [31:0] mem_inst;
    logic [31:0] fetch_pc;
    logic [31:0] inst_out;
    logic        pc_stall;
    logic        pc_restore;
    logic [31:0] saved_pc;
    logic [3:0]  inj_count;
    logic        seq_done;
    logic        overrun;

    modport master (
        output sys_active, sys_inst, mem_inst, fetch_pc,
        input  inst_out, pc_stall, pc_restore, saved_pc, inj_count, seq_done, overrun
    );

    modport slave (
        input  sys_active, sys_inst, mem_inst, fetch_pc,
        output inst_out, pc_stall, pc_restore, saved_pc, inj_count, seq_done, overrun
    );
endinterface

// File: rtl/sys_inst_injector.sv
// sys_inst_injector
//   Fetch-stage injector. While the system instruction sequencer is active,
//   its words replace instruction-memory output and the PC is held. When the
//   stream ends (or MAX_INJ words have been taken) the pipeline is flushed
//   with DRAIN_CYCLES NOPs, then a one-cycle restore pulse reloads the PC
//   from saved_pc.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high
//     bus    - sys_inst_injector_if.slave (stream in, memory word/PC in,
//              decode word and PC control out)
module sys_inst_injector #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MAX_INJ      = 14,
    parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    sys_inst_injector_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INJECT  = 2'd1,
        DRAIN   = 2'd2,
        RESTORE = 2'd3
    } state_t;

    localparam logic [3:0] INJ_MAX    = 4'(MAX_INJ);
    localparam logic [3:0] INJ_LAST   = 4'(MAX_INJ - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t      state, state_next;
    logic        active_d1;
    logic        pending;
    logic        overrun_r;
    logic [31:0] saved_pc_r;
    logic [3:0]  inj_count_r;
    logic [2:0]  drain_cnt;
    logic        start;
    logic        begin_seq;
    logic        last_word;

    assign start     = bus.sys_active & ~active_d1;
    assign begin_seq = start | pending;
    // Word at the MAX_INJ limit is still injected, then the sequence is cut off.
    assign last_word = bus.sys_active && (inj_count_r == INJ_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (begin_seq) state_next = INJECT;
            INJECT:  if (!bus.sys_active || last_word) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = RESTORE;
            RESTORE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.inst_out   = bus.mem_inst;
        bus.pc_stall   = 1'b0;
        bus.pc_restore = 1'b0;
        bus.seq_done   = 1'b0;
        unique case (state)
            IDLE: ;
            INJECT: begin
                bus.pc_stall = 1'b1;
                if (bus.sys_active && bus.sys_inst != '0) begin
                    bus.inst_out = bus.sys_inst;
                end else begin
                    bus.inst_out = NOP_WORD;
                end
            end
            DRAIN: begin
                bus.pc_stall = 1'b1;
                bus.inst_out = NOP_WORD;
            end
            RESTORE: begin
                bus.pc_stall   = 1'b1;
                bus.pc_restore = 1'b1;
                bus.seq_done   = 1'b1;
                bus.inst_out   = NOP_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_d1   <= 1'b0;
            pending     <= 1'b0;
            overrun_r   <= 1'b0;
            saved_pc_r  <= '0;
            inj_count_r <= '0;
            drain_cnt   <= '0;
        end else begin
            active_d1 <= bus.sys_active;
            unique case (state)
                IDLE: begin
                    if (begin_seq) begin
                        saved_pc_r  <= bus.fetch_pc;
                        inj_count_r <= '0;
                        pending     <= 1'b0;
                    end
                end
                INJECT: begin
                    drain_cnt <= '0;
                    if (bus.sys_active) begin
                        if (inj_count_r != INJ_MAX) inj_count_r <= inj_count_r + 4'd1;
                        if (last_word) overrun_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (start) pending <= 1'b1;
                end
                RESTORE: begin
                    if (start) pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.saved_pc  = saved_pc_r;
    assign bus.inj_count = inj_count_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_sys_inst_injector.sv
// tb_sys_inst_injector
//   Self-checking bench for sys_inst_injector: directed scenarios followed by
//   randomized sequencer traffic, all compared every cycle against a
//   sequence-level reference model (words taken, NOP tail length, pending
//   restart, sticky overrun).
module tb_sys_inst_injector;

    localparam int DRAIN = 2;
    localparam int MAXW  = 14;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sys_inst_injector_if bif ();

    sys_inst_injector #(
        .DRAIN_CYCLES(DRAIN),
        .MAX_INJ     (MAXW),
        .NOP_WORD    (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a sequence is either taking words, or burning a NOP
    // tail whose final cycle is the restore pulse.
    bit          m_prev;
    bit          m_seq;
    bit          m_taking;
    int          m_words;
    int          m_tail;
    bit          m_pend;
    logic [31:0] m_spc;
    bit          m_ovr;

    task automatic model_reset();
        m_prev = 0; m_seq = 0; m_taking = 0; m_words = 0;
        m_tail = 0; m_pend = 0; m_spc = '0; m_ovr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] e_out;
        bit          e_stall;
        bit          e_rst;
        bit          st;
        @(negedge clk);
        st = bif.sys_active && !m_prev;
        if (reset || !m_seq) begin
            e_out = bif.mem_inst; e_stall = 0; e_rst = 0;
        end else if (m_taking) begin
            e_stall = 1; e_rst = 0;
            if (!bif.sys_active || bif.sys_inst == 32'd0) e_out = NOP;
            else e_out = bif.sys_inst;
        end else begin
            e_stall = 1; e_out = NOP; e_rst = (m_tail == 1);
        end
        chk("inst_out",   bif.inst_out,          e_out);
        chk("pc_stall",   {31'd0, bif.pc_stall},   {31'd0, e_stall});
        chk("pc_restore", {31'd0, bif.pc_restore}, {31'd0, e_rst});
        chk("seq_done",   {31'd0, bif.seq_done},   {31'd0, e_rst});
        chk("saved_pc",   bif.saved_pc,          m_spc);
        chk("inj_count",  {28'd0, bif.inj_count}, 32'(m_words));
        chk("overrun",    {31'd0, bif.overrun},    {31'd0, m_ovr});
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (!m_seq) begin
                if (st || m_pend) begin
                    m_seq = 1; m_taking = 1; m_words = 0; m_pend = 0;
                    m_spc = bif.fetch_pc;
                end
            end else if (m_taking) begin
                if (!bif.sys_active) begin
                    m_taking = 0; m_tail = DRAIN + 1;
                end else begin
                    m_words++;
                    if (m_words == MAXW) begin
                        m_ovr = 1; m_taking = 0; m_tail = DRAIN + 1;
                    end
                end
            end else begin
                if (st) m_pend = 1;
                m_tail--;
                if (m_tail == 0) m_seq = 0;
            end
            m_prev = bif.sys_active;
        end
        #1;
    endtask

    task automatic drive(input bit act, input logic [31:0] word);
        bif.sys_active = act;
        bif.sys_inst   = word;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        reset = 1'b1;
        bif.sys_active = 1'b0;
        bif.sys_inst   = '0;
        bif.mem_inst   = 32'h00500093;
        bif.fetch_pc   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Pass-through
        bif.mem_inst = 32'h00500093;
        cycle();
        chk("pass_inst", bif.inst_out, 32'h00500093);
        chk("pass_stall", {31'd0, bif.pc_stall}, 32'd0);

        // Basic sequence: flag rises, then words A..D, then stream ends
        bif.fetch_pc = 32'h40;
        drive(1, 32'hDEAD0000);
        cycle();
        bif.fetch_pc = 32'h44;
        drive(1, 32'h0000A0B3); cycle();
        drive(1, 32'h0000B0B3); cycle();
        drive(1, 32'h0000C0B3); cycle();
        drive(1, 32'h0000D0B3); cycle();
        drive(0, 32'h0);
        repeat (4) cycle();
        chk("basic_cnt", {28'd0, bif.inj_count}, 32'd4);
        chk("basic_spc", bif.saved_pc, 32'h40);
        chk("basic_idle", {31'd0, bif.pc_stall}, 32'd0);

        // Zero substitution
        drive(1, 32'h0); cycle();
        drive(1, 32'h0); cycle();
        #1 chk("zero_sub", bif.inst_out, NOP);
        cycle();
        drive(0, 32'h0);
        repeat (4) cycle();

        // Overrun: flag held for 20 word slots
        drive(1, 32'h11111111); cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h00100000 + 32'(i));
            cycle();
        end
        chk("ovr_cnt", {28'd0, bif.inj_count}, 32'd14);
        chk("ovr_flag", {31'd0, bif.overrun}, 32'd1);
        drive(0, 32'h0); cycle();
        drive(1, 32'h22220000); cycle();
        drive(1, 32'h22220001); cycle();
        drive(0, 32'h0);
        repeat (4) cycle();
        chk("ovr_sticky", {31'd0, bif.overrun}, 32'd1);

        // Re-trigger during drain
        bif.fetch_pc = 32'h100;
        drive(1, 32'h3); cycle();
        drive(1, 32'h33330001); cycle();
        drive(1, 32'h33330002); cycle();
        drive(0, 32'h0); cycle();
        drive(1, 32'h44440000); cycle();
        drive(1, 32'h44440001); cycle();
        drive(1, 32'h44440002); cycle();
        bif.fetch_pc = 32'h80;
        cycle();
        chk("retrig_spc", bif.saved_pc, 32'h80);
        chk("retrig_stall", {31'd0, bif.pc_stall}, 32'd1);
        drive(1, 32'h44440003); cycle();
        drive(0, 32'h0);
        repeat (4) cycle();

        // Reset mid-INJECT
        bif.fetch_pc = 32'h200;
        drive(1, 32'h5); cycle();
        drive(1, 32'h55550001); cycle();
        drive(1, 32'h55550002);
        reset = 1'b1;
        #1;
        chk("rst_stall", {31'd0, bif.pc_stall}, 32'd0);
        chk("rst_inst", bif.inst_out, bif.mem_inst);
        chk("rst_restore", {31'd0, bif.pc_restore}, 32'd0);
        chk("rst_done", {31'd0, bif.seq_done}, 32'd0);
        chk("rst_spc", bif.saved_pc, 32'd0);
        chk("rst_cnt", {28'd0, bif.inj_count}, 32'd0);
        chk("rst_ovr", {31'd0, bif.overrun}, 32'd0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        drive(0, 32'h0);
        cycle();

        // Randomized traffic
        begin
            bit lvl;
            int run;
            lvl = 0;
            run = 0;
            for (int c = 0; c < 1500; c++) begin
                if (run == 0) begin
                    lvl = ~lvl;
                    run = lvl ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 7));
                end
                run--;
                bif.sys_active = lvl;
                bif.sys_inst   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                bif.mem_inst   = $urandom;
                bif.fetch_pc   = $urandom;
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_inst_injector.md
# sys_inst_injector

Fetch-stage injector consuming the system instruction stream (`sys_active`/`sys_inst`) produced by the system instruction sequencer. While a sequence is active it substitutes the streamed words for instruction-memory output, stalls the PC, and on completion flushes the pipeline with NOPs and restores the interrupted PC. It sits between instruction memory and the decode stage, on the same clock as the sequencer.

## Interface
- `DRAIN_CYCLES`, 2: NOP cycles emitted after the stream ends (1..7).
- `MAX_INJ`, 14: maximum words accepted per sequence before forced termination (1..15).
- `NOP_WORD`, 32'h00000013: canonical NOP (addi x0,x0,0).
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `sys_active` in 1: sequencer active flag, synchronous to `clk`.
- `sys_inst` in 32: current sequencer word.
- `mem_inst` in 32: instruction-memory word for `fetch_pc`.
- `fetch_pc` in 32: current PC.
- `inst_out` out 32: word to decode.
- `pc_stall` out 1: hold PC.
- `pc_restore` out 1: one-cycle pulse, load PC from `saved_pc`.
- `saved_pc` out 32: PC captured at sequence start.
- `inj_count` out 4: words injected in current/last sequence.
- `seq_done` out 1: one-cycle pulse with `pc_restore`.
- `overrun` out 1: sticky, set on MAX_INJ termination.

## Operation
- States: IDLE, INJECT, DRAIN, RESTORE. Registered `active_d1` = `sys_active` last cycle.
- `start` = `sys_active & ~active_d1`.
- IDLE: `inst_out = mem_inst`, `pc_stall = 0`. On `start` (or `pending`): `saved_pc <= fetch_pc`, `inj_count <= 0`, clear `pending` -> INJECT.
- INJECT: `pc_stall = 1`; `inst_out = (sys_inst == 0) ? NOP_WORD : sys_inst`; `inj_count` increments each cycle, saturating at MAX_INJ.
  - `sys_active == 0` -> DRAIN (the sampled cycle is not counted or injected; `inst_out = NOP_WORD`).
  - `inj_count == MAX_INJ-1` while still active -> that word injected, `overrun <= 1`, -> DRAIN.
- DRAIN: `pc_stall = 1`, `inst_out = NOP_WORD`; drain counter counts DRAIN_CYCLES cycles -> RESTORE.
- RESTORE: `pc_stall = 1`, `pc_restore = 1`, `seq_done = 1`, `inst_out = NOP_WORD` -> IDLE.
- A `start` seen in DRAIN/RESTORE sets `pending`; the new sequence begins in the cycle after IDLE is reached. `pending` does not re-capture `saved_pc` until IDLE.
- `overrun` cleared only by reset.
- `inj_count` holds its final value in IDLE until the next start.

## Timing
- Reset (async): state IDLE; `active_d1`, `pending`, `overrun`, `pc_restore`, `seq_done`, `pc_stall` = 0; `saved_pc` = 0; `inj_count` = 0; `inst_out` = `mem_inst` (combinational).
- `inst_out`, `pc_stall`, `pc_restore`, `seq_done` are combinational decodes of state and inputs. No output registers.
- `start` sampled at edge k -> INJECT from edge k. The first injected word is `sys_inst` during cycle k..k+1.
- A sequence of N words (N < MAX_INJ) costs N + 1 + DRAIN_CYCLES + 1 stalled cycles.
- Reset mid-sequence aborts immediately: no `pc_restore` is issued, and the PC owner handles reset independently.

## Test plan
- Pass-through: IDLE, `mem_inst`=32'h00500093 -> `inst_out` = 32'h00500093, `pc_stall` = 0.
- Basic sequence: `fetch_pc` = 0x40, `sys_active` high for 4 cycles with words A,B,C,D -> `inst_out` = A,B,C,D, then 3 NOPs (including the DRAIN_CYCLES = 2 drain), then `pc_restore` + `seq_done` with `saved_pc` = 0x40, `inj_count` = 4.
- Zero substitution: `sys_inst` = 0 during INJECT -> `inst_out` = 32'h00000013.
- Overrun: `sys_active` held 20 cycles -> exactly 14 words injected, `overrun` = 1, DRAIN entered, and `overrun` stays 1 through the next sequence.
- Re-trigger: `sys_active` falls, then rises during DRAIN -> `pending` set; after RESTORE → IDLE, INJECT re-entered one cycle later, with `saved_pc` capturing the then-current `fetch_pc`.
- Reset mid-INJECT: assert `reset` at word 2 -> immediate IDLE, all outputs at reset values, with no `pc_restore` pulse.
